riscv_mem_arbiter: RTL

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

---
 rtl/riscv_mem_arbiter_if.sv | 66 ++++++
 rtl/riscv_mem_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter_if.sv
// Request, response and memory bus signals of the instruction/data memory arbiter.
// The master view belongs to the arbiter; the slave view belongs to requesters and memory.
interface riscv_mem_arbiter_if;
    logic        instr_read;
    logic [31:0] instr_address;
    logic [31:0] instr_value;
    logic        instr_ready;

    logic        data_read;
    logic        data_write;
    logic [31:0] data_address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_ready;

    logic [31:0] memory_address;
    logic [31:0] memory_out;
    logic        memory_read;
    logic        memory_write;
    logic [31:0] memory_in;
    logic        memory_read_ready;
    logic        memory_write_ready;
    logic        bus_error;

    modport master (
        input  instr_read,
        input  instr_address,
        input  data_read,
        input  data_write,
        input  data_address,
        input  data_in,
        input  memory_in,
        input  memory_read_ready,
        input  memory_write_ready,
        output instr_value,
        output instr_ready,
        output data_out,
        output data_ready,
        output memory_address,
        output memory_out,
        output memory_read,
        output memory_write,
        output bus_error
    );

    modport slave (
        output instr_read,
        output instr_address,
        output data_read,
        output data_write,
        output data_address,
        output data_in,
        output memory_in,
        output memory_read_ready,
        output memory_write_ready,
        input  instr_value,
        input  instr_ready,
        input  data_out,
        input  data_ready,
        input  memory_address,
        input  memory_out,
        input  memory_read,
        input  memory_write,
        input  bus_error
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access,
// with bounded data starvation and a wait-state timeout.
module riscv_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    riscv_mem_arbiter_if.master   bus
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
    localparam logic STARVE_ON = (STARVE_LIMIT != 0);
    localparam logic [7:0] TO_LAST = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_nx;
    logic        owner_q, owner_nx;
    logic        write_q, write_nx;
    logic [31:0] addr_q, addr_nx;
    logic [31:0] wdata_q, wdata_nx;
    logic [31:0] rdata_q, rdata_nx;
    logic        err_q, err_nx;
    logic [SW-1:0] starve_q, starve_nx;
    logic [7:0]  wait_q, wait_nx;

    logic instr_pend;
    logic data_pend;
    logic data_win;
    logic ack;

    assign instr_pend = bus.instr_read;
    assign data_pend  = bus.data_read | bus.data_write;

    // Data only overtakes a pending fetch once the starvation budget is used up.
    assign data_win = data_pend &
                      (~instr_pend | (STARVE_ON & (starve_q == SLIM)));

    assign ack = write_q ? bus.memory_write_ready : bus.memory_read_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            starve_q <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_nx;
            owner_q  <= owner_nx;
            write_q  <= write_nx;
            addr_q   <= addr_nx;
            wdata_q  <= wdata_nx;
            rdata_q  <= rdata_nx;
            err_q    <= err_nx;
            starve_q <= starve_nx;
            wait_q   <= wait_nx;
        end
    end

    always_comb begin
        state_nx  = state_q;
        owner_nx  = owner_q;
        write_nx  = write_q;
        addr_nx   = addr_q;
        wdata_nx  = wdata_q;
        rdata_nx  = rdata_q;
        err_nx    = err_q;
        starve_nx = starve_q;
        wait_nx   = wait_q;
        unique case (state_q)
            IDLE: begin
                if (instr_pend | data_pend) begin
                    state_nx = ISSUE;
                    owner_nx = data_win;
                    write_nx = data_win & bus.data_write;
                    addr_nx  = data_win ? bus.data_address : bus.instr_address;
                    wdata_nx = data_win ? bus.data_in : '0;
                    rdata_nx = '0;
                    err_nx   = 1'b0;
                    if (data_win) begin
                        starve_nx = '0;
                    end else if (data_pend && (starve_q != SLIM)) begin
                        starve_nx = starve_q + SW'(1);
                    end
                end
            end
            ISSUE: begin
                state_nx = WAIT;
                wait_nx  = '0;
            end
            WAIT: begin
                if (ack) begin
                    state_nx = RESP;
                    rdata_nx = write_q ? '0 : bus.memory_in;
                end else if (wait_q == TO_LAST) begin
                    state_nx = RESP;
                    rdata_nx = '0;
                    err_nx   = 1'b1;
                end else begin
                    wait_nx = wait_q + 8'd1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    logic busy;
    logic resp;

    assign busy = (state_q == ISSUE) | (state_q == WAIT);
    assign resp = (state_q == RESP);

    assign bus.memory_read    = (state_q == ISSUE) & ~write_q;
    assign bus.memory_write   = (state_q == ISSUE) & write_q;
    assign bus.memory_address = busy ? addr_q : '0;
    assign bus.memory_out     = busy ? wdata_q : '0;

    assign bus.instr_ready = resp & ~owner_q;
    assign bus.data_ready  = resp & owner_q;
    assign bus.instr_value = bus.instr_ready ? rdata_q : '0;
    assign bus.data_out    = bus.data_ready ? rdata_q : '0;
    assign bus.bus_error   = resp & err_q;

endmodule
